// File: rtl/router_pkg.sv
// Shared types and sizing helpers for the datapath pool router.
package router_pkg;
  localparam int DEF_INSTR_W  = 32;
  localparam int DEF_RESULT_W = 16;

  // Index width that stays at least one bit for single-entry tables.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {IDLE, PENDING, ISSUED} port_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational search for the first set request at or after ptr, wrapping.
module rr_arbiter
  import router_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);
  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = N-1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(j);
      end
    end
  end
endmodule

// File: rtl/datapath_pool_router.sv
// Round-robin router from PORTS requesters onto a pool of UNITS datapath units,
// with out-of-order completion and a sticky protocol error flag.
module datapath_pool_router
  import router_pkg::*;
#(
  parameter int PORTS    = 4,
  parameter int UNITS    = 2,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int RESULT_W = DEF_RESULT_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [PORTS*INSTR_W-1:0]    instruction,
  input  logic [PORTS-1:0]            start,
  output logic [PORTS*RESULT_W-1:0]   result,
  output logic [PORTS-1:0]            finished,
  output logic [UNITS*INSTR_W-1:0]    instruction_dp,
  output logic [UNITS-1:0]            start_dp,
  input  logic [UNITS*RESULT_W-1:0]   result_dp,
  input  logic [UNITS-1:0]            finished_dp,
  output logic [$clog2(UNITS+1)-1:0]  busy_units,
  output logic                        protocol_error
);
  localparam int PW = idx_w(PORTS);
  localparam int UW = idx_w(UNITS);
  localparam int BW = $clog2(UNITS+1);

  logic [PORTS-1:0][INSTR_W-1:0]  instr_v, req_buf;
  logic [PORTS-1:0][RESULT_W-1:0] result_q;
  logic [UNITS-1:0][INSTR_W-1:0]  instr_dp_q;
  logic [UNITS-1:0][RESULT_W-1:0] result_dp_v;
  logic [UNITS-1:0][PW-1:0]       owner;
  port_state_t                    st [PORTS];

  logic [PORTS-1:0] pend, fin;
  logic [UNITS-1:0] busy, busy_nxt, done, spurious, unit_onehot;
  logic [PW-1:0]    rr_ptr, p_idx;
  logic [UW-1:0]    u_idx;
  logic             p_vld, u_vld, dispatch, rst_d, proto_hit;
  logic [BW-1:0]    busy_cnt;

  assign instr_v        = instruction;
  assign result_dp_v    = result_dp;
  assign result         = result_q;
  assign instruction_dp = instr_dp_q;
  assign finished       = fin;

  always_comb begin
    pend = '0;
    fin  = '0;
    for (int i = 0; i < PORTS; i++) begin
      pend[i] = (st[i] == PENDING);
      fin[i]  = (st[i] == IDLE);
    end
  end

  rr_arbiter #(.N(PORTS), .IW(PW)) u_port_arb (
    .req(pend), .ptr(rr_ptr), .grant_valid(p_vld), .grant_idx(p_idx)
  );

  rr_arbiter #(.N(UNITS), .IW(UW)) u_unit_arb (
    .req(~busy), .ptr({UW{1'b0}}), .grant_valid(u_vld), .grant_idx(u_idx)
  );

  assign dispatch = p_vld & u_vld;

  // Completion pulses in the first cycle after reset belong to abandoned work.
  assign done      = finished_dp &  busy & {UNITS{~rst_d}};
  assign spurious  = finished_dp & ~busy & {UNITS{~rst_d}};
  assign proto_hit = (|(start & ~fin)) | (|spurious);

  always_comb begin
    unit_onehot = '0;
    if (dispatch) unit_onehot[u_idx] = 1'b1;
    busy_nxt = (busy & ~done) | unit_onehot;
    busy_cnt = '0;
    for (int u = 0; u < UNITS; u++) busy_cnt = busy_cnt + BW'(busy_nxt[u]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PORTS; i++) st[i] <= IDLE;
      req_buf        <= '0;
      result_q       <= '0;
      instr_dp_q     <= '0;
      start_dp       <= '0;
      busy           <= '0;
      owner          <= '0;
      rr_ptr         <= '0;
      busy_units     <= '0;
      protocol_error <= 1'b0;
      rst_d          <= 1'b1;
    end else begin
      rst_d      <= 1'b0;
      start_dp   <= '0;
      busy       <= busy_nxt;
      busy_units <= busy_cnt;
      if (proto_hit) protocol_error <= 1'b1;

      for (int i = 0; i < PORTS; i++) begin
        if (start[i] && st[i] == IDLE) begin
          st[i]      <= PENDING;
          req_buf[i] <= instr_v[i];
        end
      end

      if (dispatch) begin
        instr_dp_q[u_idx] <= req_buf[p_idx];
        start_dp[u_idx]   <= 1'b1;
        owner[u_idx]      <= p_idx;
        st[p_idx]         <= ISSUED;
        rr_ptr            <= (p_idx == PW'(PORTS-1)) ? '0 : p_idx + 1'b1;
      end

      // Owners of simultaneously completing units are always distinct ports.
      for (int u = 0; u < UNITS; u++) begin
        if (done[u]) begin
          result_q[owner[u]] <= result_dp_v[u];
          st[owner[u]]       <= IDLE;
        end
      end
    end
  end
endmodule
